voice_mixer: RTL and testbench

Per-sample voice mixer that produces the 8-bit sample stream for the state-variable filter, and a parallel unfiltered sample. It runs on a fixed sample-rate tick from an internal clock divider. On each tick it latches the three voice waveforms and envelopes. It then scales each voice by its envelope through one shared multiplier, one voice per cycle. Each scaled voice is steered into the filtered or the direct accumulator according to the filter routing bits. A one-cycle `filt_valid` strobe accompanies each new `filt_sample`, which connects directly to the filter's `sample_in`/`sample_valid`.

---
 rtl/voice_mixer.sv | 166 ++++++++++++++++
 tb/tb_voice_mixer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Per-sample three-voice mixer: scales each voice by its envelope through one
// shared multiplier and splits the results into filtered and direct mixes.
module voice_mixer #(
  parameter int unsigned CLK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] voice_wave,
  input  logic [23:0] voice_env,
  input  logic [3:0]  filt,
  input  logic        voice3off,
  output logic [7:0]  filt_sample,
  output logic        filt_valid,
  output logic [7:0]  direct_sample,
  output logic        busy
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    V0    = 3'd2,
    V1    = 3'd3,
    V2    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] div_cnt;
  logic          tick;

  logic [23:0]   wave_l;
  logic [23:0]   env_l;
  logic [2:0]    filt_l;
  logic          v3off_l;
  logic signed [10:0] facc;
  logic signed [10:0] dacc;

  logic [7:0]    sel_wave;
  logic [7:0]    sel_env;
  logic          sel_route;
  logic          sel_mute;
  logic signed [8:0]  s;
  logic signed [8:0]  env_s;
  logic signed [17:0] prod;
  logic signed [10:0] v;

  // Saturate to signed 8-bit, then offset-binary by flipping the sign bit.
  function automatic logic [7:0] to_sample(input logic signed [10:0] a);
    if (a > 11'sd127)
      return 8'hFF;
    else if (a < -11'sd128)
      return 8'h00;
    else
      return {~a[7], a[6:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (div_cnt == DW'(CLK_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick)
          state_next = LATCH;
      end
      LATCH:   state_next = V0;
      V0:      state_next = V1;
      V1:      state_next = V2;
      V2:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_wave  = '0;
    sel_env   = '0;
    sel_route = 1'b0;
    sel_mute  = 1'b0;
    case (state)
      V0: begin
        sel_wave  = wave_l[7:0];
        sel_env   = env_l[7:0];
        sel_route = filt_l[0];
      end
      V1: begin
        sel_wave  = wave_l[15:8];
        sel_env   = env_l[15:8];
        sel_route = filt_l[1];
      end
      V2: begin
        sel_wave  = wave_l[23:16];
        sel_env   = env_l[23:16];
        sel_route = filt_l[2];
        sel_mute  = v3off_l;
      end
      default: ;
    endcase
  end

  // Single shared multiplier; the arithmetic shift by 8 floors toward -inf.
  assign s     = $signed({1'b0, sel_wave}) - 9'sd128;
  assign env_s = $signed({1'b0, sel_env});
  assign prod  = s * env_s;
  assign v     = {prod[17], prod[17:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_l        <= '0;
      env_l         <= '0;
      filt_l        <= '0;
      v3off_l       <= 1'b0;
      facc          <= '0;
      dacc          <= '0;
      filt_sample   <= 8'h80;
      direct_sample <= 8'h80;
      filt_valid    <= 1'b0;
    end else begin
      filt_valid <= 1'b0;
      case (state)
        LATCH: begin
          wave_l  <= voice_wave;
          env_l   <= voice_env;
          filt_l  <= filt[2:0];
          v3off_l <= voice3off;
          facc    <= '0;
          dacc    <= '0;
        end
        V0, V1, V2: begin
          if (sel_route)
            facc <= facc + v;
          else if (!sel_mute)
            dacc <= dacc + v;
        end
        DONE: begin
          filt_sample   <= to_sample(facc);
          direct_sample <= to_sample(dacc);
          filt_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer at CLK_DIV=8: directed frames with
// hand-computed results; a monitor checks every filt_valid pulse.
module tb_voice_mixer;

  logic        clk;
  logic        rst_n;
  logic [23:0] voice_wave;
  logic [23:0] voice_env;
  logic [3:0]  filt;
  logic        voice3off;
  logic [7:0]  filt_sample;
  logic        filt_valid;
  logic [7:0]  direct_sample;
  logic        busy;

  voice_mixer #(.CLK_DIV(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .voice_wave    (voice_wave),
    .voice_env     (voice_env),
    .filt          (filt),
    .voice3off     (voice3off),
    .filt_sample   (filt_sample),
    .filt_valid    (filt_valid),
    .direct_sample (direct_sample),
    .busy          (busy)
  );

  typedef struct {
    int         edge_no;
    logic [7:0] f;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot  = 0;
  int   edge_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges since the last reset release; edge 1 is the first after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp)
      npass++;
    else
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (filt_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_edge", edge_cnt, e.edge_no);
          chk("filt_sample", int'(filt_sample), int'(e.f));
          chk("direct_sample", int'(direct_sample), int'(e.d));
        end
      end else if (q.size() != 0 && edge_cnt > q[0].edge_no) begin
        chk("missing_pulse", edge_cnt, q[0].edge_no);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_cnt < n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (edge_cnt < n) chk("wait_timeout", edge_cnt, n);
  endtask

  task automatic set_in(input logic [23:0] w, input logic [23:0] e,
                        input logic [3:0] f, input logic v3);
    voice_wave = w;
    voice_env  = e;
    filt       = f;
    voice3off  = v3;
  endtask

  task automatic expect_frame(input int n, input logic [7:0] f, input logic [7:0] d);
    exp_t e;
    e.edge_no = 8 * n + 5;
    e.f       = f;
    e.d       = d;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_filt"}, int'(filt_sample), 'h80);
    chk({tag, "_direct"}, int'(direct_sample), 'h80);
    chk({tag, "_valid"}, int'(filt_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(24'hFFFFFF, 24'hFFFFFF, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Frame 1: all voices full scale into the direct path: 3*126 clamps high.
    expect_frame(1, 8'h80, 8'hFF);
    @(negedge clk);
    check_reset_outputs("post_rst");
    wait_edge(13);

    // Frame 2: voice0 at wave 0 routed to filter gives -128.
    set_in(24'hFFFF00, 24'h0000FF, 4'b0001, 1'b0);
    expect_frame(2, 8'h00, 8'h80);
    wait_edge(21);

    // Frames 3-5: voice2 contributes +32; voice3off mutes only the direct path.
    set_in(24'hC08080, 24'h800000, 4'b0000, 1'b1);
    expect_frame(3, 8'h80, 8'h80);
    wait_edge(29);
    set_in(24'hC08080, 24'h800000, 4'b0000, 1'b0);
    expect_frame(4, 8'h80, 8'hA0);
    wait_edge(37);
    set_in(24'hC08080, 24'h800000, 4'b1100, 1'b1);
    expect_frame(5, 8'hA0, 8'h80);
    wait_edge(45);

    // Frame 6: filt +126 -> 0xFE; direct -64 + 32 = -32 -> 0x60.
    set_in(24'hC000FF, 24'h8080FF, 4'b0001, 1'b0);
    expect_frame(6, 8'hFE, 8'h60);
    wait_edge(53);

    // Frame 7: envelopes dropped after the latch must not affect this frame.
    set_in(24'hFFFFFF, 24'hFFFFFF, 4'b0000, 1'b0);
    expect_frame(7, 8'h80, 8'hFF);
    wait_edge(58);
    chk("busy_mid_frame", int'(busy), 1);
    voice_env = 24'h000000;
    expect_frame(8, 8'h80, 8'h80);
    wait_edge(61);
    chk("busy_after_done", int'(busy), 0);
    wait_edge(69);

    // Frame 9 sets direct to 0xFF, then frame 10 is aborted by reset.
    set_in(24'hFFFFFF, 24'hFFFFFF, 4'b0000, 1'b0);
    expect_frame(9, 8'h80, 8'hFF);
    wait_edge(83);
    chk("queue_drained_before_abort", q.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;

    expect_frame(1, 8'h80, 8'hFF);
    @(negedge clk);
    check_reset_outputs("post_abort");
    wait_edge(16);
    chk("queue_drained_end", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
